datamem_pipelined: RTL and testbench

Parametrised successor to the team's two-dimensional data memory. It is a single-port data RAM with a valid/ready request and response interface, per-byte write strobes, and a configurable read latency. Out-of-range addresses are detected and flagged. It sits between the load/store unit and on-chip data storage. Every accepted request produces exactly one in-order response, and a response FIFO sized by credit absorbs response-side backpressure without dropping data.

---
 rtl/datamem_pipelined_if.sv | 29 ++
 rtl/datamem_pipelined.sv | 117 +++++++++++
 tb/tb_datamem_pipelined.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/datamem_pipelined_if.sv
// datamem_pipelined_if: request/response bus between a load/store unit
// (master) and datamem_pipelined (slave).
//   Req_valid/Req_ready/Req_write/Req_addr/Req_wdata/Req_wstrb : request channel
//   Resp_valid/Resp_ready/Resp_rdata/Resp_error                 : response channel
interface datamem_pipelined_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_BITS  = 16
);
  logic                    Req_valid;
  logic                    Req_ready;
  logic                    Req_write;
  logic [ADDR_BITS-1:0]    Req_addr;
  logic [DATA_WIDTH-1:0]   Req_wdata;
  logic [DATA_WIDTH/8-1:0] Req_wstrb;
  logic                    Resp_valid;
  logic                    Resp_ready;
  logic [DATA_WIDTH-1:0]   Resp_rdata;
  logic                    Resp_error;

  modport master (
    output Req_valid, Req_write, Req_addr, Req_wdata, Req_wstrb, Resp_ready,
    input  Req_ready, Resp_valid, Resp_rdata, Resp_error
  );

  modport slave (
    input  Req_valid, Req_write, Req_addr, Req_wdata, Req_wstrb, Resp_ready,
    output Req_ready, Resp_valid, Resp_rdata, Resp_error
  );
endinterface

// File: rtl/datamem_pipelined.sv
// datamem_pipelined: single-port data RAM with byte write strobes, a
// READ_LATENCY-stage response pipeline and a credit-sized response FIFO.
// Ports:
//   Clock   : rising-edge clock
//   Reset_n : asynchronous active-low reset (clears pipeline, FIFO, credits;
//             memory contents are kept)
//   bus     : datamem_pipelined_if slave (request in, response out)
// Out-of-range addresses (>= DEPTH) suppress writes, read as 0 and set
// Resp_error on their response.
module datamem_pipelined #(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned ADDR_BITS    = 16,
  parameter int unsigned DEPTH        = 1 << ADDR_BITS,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic               Clock,
  input  logic               Reset_n,
  datamem_pipelined_if.slave bus
);

  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam int unsigned FD = READ_LATENCY + 1;
  localparam int unsigned PW = $clog2(FD);
  localparam int unsigned CW = $clog2(FD + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_BITS:0] DEPTH_W = (ADDR_BITS + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  logic                  accept;
  logic                  push;
  logic                  pop;
  logic                  in_range;
  logic [AW-1:0]         idx;
  logic [DATA_WIDTH-1:0] rd_word;

  logic                  pv_q [READ_LATENCY];
  logic                  pe_q [READ_LATENCY];
  logic [DATA_WIDTH-1:0] pd_q [READ_LATENCY];

  logic [DATA_WIDTH-1:0] fd_q [FD];
  logic                  fe_q [FD];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] fcnt_q, fcnt_d;
  logic [CW-1:0] outst_q, outst_d;

  always_comb begin
    // Credits cover pipeline plus FIFO, so a full credit count means the
    // FIFO can absorb every in-flight response.
    bus.Req_ready  = outst_q < CW'(FD);
    accept         = bus.Req_valid && bus.Req_ready;
    in_range       = {1'b0, bus.Req_addr} < DEPTH_W;
    idx            = bus.Req_addr[AW-1:0];
    rd_word        = (in_range && !bus.Req_write) ? mem[idx] : '0;

    push           = pv_q[READ_LATENCY-1];
    bus.Resp_valid = fcnt_q != '0;
    pop            = bus.Resp_valid && bus.Resp_ready;
    bus.Resp_rdata = bus.Resp_valid ? fd_q[rd_ptr_q] : '0;
    bus.Resp_error = bus.Resp_valid ? fe_q[rd_ptr_q] : 1'b0;

    wr_ptr_d = wr_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == PW'(FD - 1)) ? '0 : wr_ptr_q + PW'(1);
    rd_ptr_d = rd_ptr_q;
    if (pop) rd_ptr_d = (rd_ptr_q == PW'(FD - 1)) ? '0 : rd_ptr_q + PW'(1);

    fcnt_d  = fcnt_q + CW'(push) - CW'(pop);
    outst_d = outst_q + CW'(accept) - CW'(pop);
  end

  // Memory has no reset; writes are held off while Reset_n is low.
  always_ff @(posedge Clock) begin
    if (Reset_n && accept && bus.Req_write && in_range) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (bus.Req_wstrb[b]) mem[idx][8*b +: 8] <= bus.Req_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        pv_q[i] <= 1'b0;
        pe_q[i] <= 1'b0;
        pd_q[i] <= '0;
      end
      for (int unsigned i = 0; i < FD; i++) begin
        fd_q[i] <= '0;
        fe_q[i] <= 1'b0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
      outst_q  <= '0;
    end else begin
      pv_q[0] <= accept;
      pe_q[0] <= !in_range;
      pd_q[0] <= rd_word;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        pv_q[i] <= pv_q[i-1];
        pe_q[i] <= pe_q[i-1];
        pd_q[i] <= pd_q[i-1];
      end
      if (push) begin
        fd_q[wr_ptr_q] <= pd_q[READ_LATENCY-1];
        fe_q[wr_ptr_q] <= pe_q[READ_LATENCY-1];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fcnt_q   <= fcnt_d;
      outst_q  <= outst_d;
    end
  end

endmodule

// File: tb/tb_datamem_pipelined.sv
module tb_datamem_pipelined;
  localparam int unsigned DW  = 64;
  localparam int unsigned AB  = 16;
  localparam int unsigned DEP = 1000;
  localparam int unsigned RL  = 2;
  localparam int unsigned FD  = RL + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  datamem_pipelined_if #(.DATA_WIDTH(DW), .ADDR_BITS(AB)) bus();

  datamem_pipelined #(
    .DATA_WIDTH(DW), .ADDR_BITS(AB), .DEPTH(DEP), .READ_LATENCY(RL)
  ) dut (
    .Clock(clk), .Reset_n(rst_n), .bus(bus)
  );

  typedef struct {
    logic        w;
    logic [15:0] a;
    logic [63:0] d;
    logic [7:0]  s;
    logic [63:0] er;
    logic        ee;
  } vec_t;

  typedef struct {
    logic [63:0] d;
    logic        e;
  } resp_t;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] mdl [DEP];
  resp_t       expq [$];
  int          model_out = 0;
  logic        acc_seen, pop_seen, pop_e;
  logic [63:0] pop_d;
  vec_t        vecs [15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: observe at the falling edge, update the reference model,
  // then return 1 time unit after the next rising edge.
  task automatic tick();
    resp_t       r;
    int unsigned ai;
    @(negedge clk);
    acc_seen = rst_n && bus.Req_valid && bus.Req_ready;
    pop_seen = rst_n && bus.Resp_valid && bus.Resp_ready;
    pop_d    = bus.Resp_rdata;
    pop_e    = bus.Resp_error;
    if (!rst_n) begin
      expq.delete();
      model_out = 0;
    end else begin
      check("req_ready", 64'(bus.Req_ready), 64'(model_out < int'(FD)));
      if (pop_seen) begin
        check("resp_pending", 64'(expq.size() != 0), 64'(1));
        if (expq.size() != 0) begin
          r = expq.pop_front();
          check("resp_rdata", pop_d, r.d);
          check("resp_error", 64'(pop_e), 64'(r.e));
        end
      end
      if (acc_seen) begin
        ai  = int'(bus.Req_addr);
        r.e = ai >= DEP;
        r.d = '0;
        if (!r.e) begin
          if (bus.Req_write) begin
            for (int b = 0; b < 8; b++)
              if (bus.Req_wstrb[b]) mdl[ai][8*b +: 8] = bus.Req_wdata[8*b +: 8];
          end else begin
            r.d = mdl[ai];
          end
        end
        expq.push_back(r);
      end
      model_out += int'(acc_seen) - int'(pop_seen);
      check("outstanding_bound", 64'(model_out <= int'(FD)), 64'(1));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic w, input logic [15:0] a, input logic [63:0] d, input logic [7:0] s);
    bus.Req_write = w;
    bus.Req_addr  = a;
    bus.Req_wdata = d;
    bus.Req_wstrb = s;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int n;
    set_req(v.w, v.a, v.d, v.s);
    bus.Req_valid  = 1'b1;
    bus.Resp_ready = 1'b1;
    n = 0;
    tick();
    while (!acc_seen && n < 20) begin tick(); n++; end
    bus.Req_valid = 1'b0;
    check({nm, "_accepted"}, 64'(acc_seen), 64'(1));
    n = 0;
    while (!bus.Resp_valid && n < 20) begin tick(); n++; end
    check({nm, "_latency"}, 64'(n), 64'(RL));
    check({nm, "_rdata"}, bus.Resp_rdata, v.er);
    check({nm, "_error"}, 64'(bus.Resp_error), 64'(v.ee));
    tick();
  endtask

  task automatic gen_rand();
    bus.Req_write = 1'($urandom_range(0, 1));
    bus.Req_addr  = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(995, 1003))
                                                : 16'($urandom_range(0, 15));
    bus.Req_wdata = {$urandom, $urandom};
    bus.Req_wstrb = 8'($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no summary, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] bp_addr [5];
    logic [63:0] raw_d [2];
    logic        raw_e [2];
    vec_t        rv;
    int          got, n, acc, pops, stale, issued;

    vecs[0]  = '{1'b1, 16'd5,     64'h1122334455667788, 8'hFF, 64'h0, 1'b0};
    vecs[1]  = '{1'b1, 16'd5,     64'hAAAAAAAAAAAAAAAA, 8'h0F, 64'h0, 1'b0};
    vecs[2]  = '{1'b0, 16'd5,     64'h0,                8'h00, 64'h11223344AAAAAAAA, 1'b0};
    vecs[3]  = '{1'b1, 16'd999,   64'h0123456789ABCDEF, 8'hF0, 64'h0, 1'b0};
    vecs[4]  = '{1'b0, 16'd999,   64'h0,                8'h00, 64'h0123456700000000, 1'b0};
    vecs[5]  = '{1'b1, 16'd1000,  64'hFF,               8'hFF, 64'h0, 1'b1};
    vecs[6]  = '{1'b0, 16'd1000,  64'h0,                8'h00, 64'h0, 1'b1};
    vecs[7]  = '{1'b0, 16'd999,   64'h0,                8'h00, 64'h0123456700000000, 1'b0};
    vecs[8]  = '{1'b1, 16'd5,     64'hFFFFFFFFFFFFFFFF, 8'h00, 64'h0, 1'b0};
    vecs[9]  = '{1'b0, 16'd5,     64'h0,                8'h00, 64'h11223344AAAAAAAA, 1'b0};
    vecs[10] = '{1'b1, 16'd0,     64'h5A5A5A5A5A5A5AC3, 8'h01, 64'h0, 1'b0};
    vecs[11] = '{1'b0, 16'd0,     64'h0,                8'h00, 64'h00000000000000C3, 1'b0};
    vecs[12] = '{1'b0, 16'd65535, 64'h0,                8'h00, 64'h0, 1'b1};
    vecs[13] = '{1'b1, 16'd999,   64'hFFFFFFFFFFFFFF11, 8'h81, 64'h0, 1'b0};
    vecs[14] = '{1'b0, 16'd999,   64'h0,                8'h00, 64'hFF23456700000011, 1'b0};

    for (int i = 0; i < int'(DEP); i++) mdl[i] = '0;
    bus.Req_valid  = 1'b0;
    bus.Resp_ready = 1'b1;
    set_req(1'b0, 16'd0, 64'h0, 8'h00);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_resp_valid", 64'(bus.Resp_valid), 64'(0));
    check("rst_req_ready", 64'(bus.Req_ready), 64'(1));
    check("rst_resp_rdata", bus.Resp_rdata, 64'h0);
    check("rst_resp_error", 64'(bus.Resp_error), 64'(0));
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 15; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back read-after-write
    set_req(1'b1, 16'd7, 64'hDEAD, 8'hFF);
    bus.Req_valid  = 1'b1;
    bus.Resp_ready = 1'b1;
    tick();
    check("raw_wr_accept", 64'(acc_seen), 64'(1));
    set_req(1'b0, 16'd7, 64'h0, 8'h00);
    tick();
    check("raw_rd_accept", 64'(acc_seen), 64'(1));
    bus.Req_valid = 1'b0;
    got = 0;
    n   = 0;
    while (got < 2 && n < 20) begin
      tick();
      if (pop_seen) begin raw_d[got] = pop_d; raw_e[got] = pop_e; got++; end
      n++;
    end
    check("raw_resp_count", 64'(got), 64'(2));
    check("raw_first_is_ack", raw_d[0], 64'h0);
    check("raw_first_error", 64'(raw_e[0]), 64'(0));
    check("raw_second_rdata", raw_d[1], 64'hDEAD);

    // Backpressure: only FD reads fit while the consumer stalls
    bp_addr = '{16'd5, 16'd999, 16'd1000, 16'd0, 16'd7};
    bus.Resp_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      bus.Req_valid = 1'b1;
      set_req(1'b0, bp_addr[acc], 64'h0, 8'h00);
      tick();
      if (acc_seen) acc++;
    end
    check("bp_accepted_stalled", 64'(acc), 64'(FD));
    check("bp_req_ready_low", 64'(bus.Req_ready), 64'(0));
    check("bp_held_valid", 64'(bus.Resp_valid), 64'(1));
    check("bp_held_rdata", bus.Resp_rdata, 64'h11223344AAAAAAAA);
    check("bp_held_error", 64'(bus.Resp_error), 64'(0));
    bus.Resp_ready = 1'b1;
    pops = 0;
    n    = 0;
    while ((acc < 5 || pops < 5) && n < 40) begin
      bus.Req_valid = (acc < 5);
      set_req(1'b0, bp_addr[(acc < 5) ? acc : 4], 64'h0, 8'h00);
      tick();
      if (acc_seen) acc++;
      if (pop_seen) begin
        pops++;
        if (pops == 1) check("bp_ready_after_first_pop", 64'(bus.Req_ready), 64'(1));
      end
      n++;
    end
    bus.Req_valid = 1'b0;
    check("bp_total_accepted", 64'(acc), 64'(5));
    check("bp_total_popped", 64'(pops), 64'(5));

    // Reset mid-stream with 3 outstanding; write during reset must not land
    bus.Resp_ready = 1'b0;
    acc = 0;
    n   = 0;
    while (acc < 3 && n < 10) begin
      bus.Req_valid = 1'b1;
      set_req(1'b0, bp_addr[acc], 64'h0, 8'h00);
      tick();
      if (acc_seen) acc++;
      n++;
    end
    bus.Req_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_resp_valid", 64'(bus.Resp_valid), 64'(0));
    check("mid_rst_req_ready", 64'(bus.Req_ready), 64'(1));
    check("mid_rst_resp_rdata", bus.Resp_rdata, 64'h0);
    check("mid_rst_resp_error", 64'(bus.Resp_error), 64'(0));
    bus.Req_valid = 1'b1;
    set_req(1'b1, 16'd0, 64'h0000000000000BAD, 8'hFF);
    tick();
    tick();
    bus.Req_valid = 1'b0;
    rst_n = 1'b1;
    bus.Resp_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (pop_seen) stale++;
    end
    check("post_rst_stale_resps", 64'(stale), 64'(0));
    check("post_rst_req_ready", 64'(bus.Req_ready), 64'(1));
    rv = '{1'b0, 16'd0, 64'h0, 8'h00, 64'h00000000000000C3, 1'b0};
    run_vec(rv, "rst_blocked_write");

    // Random stream against the reference model
    issued = 0;
    n      = 0;
    bus.Req_valid = 1'b1;
    gen_rand();
    while (issued < 256 && n < 5000) begin
      bus.Resp_ready = 1'($urandom_range(0, 1));
      tick();
      if (acc_seen) begin issued++; gen_rand(); end
      n++;
    end
    bus.Req_valid  = 1'b0;
    bus.Resp_ready = 1'b1;
    check("stream_issued", 64'(issued), 64'(256));
    n = 0;
    while (expq.size() != 0 && n < 50) begin tick(); n++; end
    tick();
    check("stream_drained", 64'(expq.size()), 64'(0));
    check("stream_resp_valid_idle", 64'(bus.Resp_valid), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
